mem_bus_arbiter: RTL and testbench

Shares the single data/instruction memory port between the instruction-fetch requester (I) and the load/store requester (D) of the memory stage. Arbitrates round-robin with one outstanding transaction, routes responses back to the owner, raises a pipeline hold while a D access is in flight, and terminates hung accesses with an error after a bounded wait. Sits between the IF and ME stages and the memory bus; hold goes to ctrl.

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_rr2.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_t;

   localparam int unsigned MAX_WAIT_DEFAULT = 15;
   localparam int unsigned WAIT_CNT_W       = 8;

   // Bit positions inside the two-bit request/grant vectors
   localparam int REQ_I = 0;
   localparam int REQ_D = 1;

endpackage

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-input round-robin picker: one-hot grant, ties resolved by last_d.
module arb_rr2
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_d,
   output logic [1:0] gnt
);

   // last_d set means D takes the next tie (it is set out of reset and after I is served)
   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt[REQ_I] = 1'b1;
         2'b10:   gnt[REQ_D] = 1'b1;
         2'b11: begin
            if (last_d) gnt[REQ_D] = 1'b1;
            else        gnt[REQ_I] = 1'b1;
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one outstanding access, with timeout.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   output logic            i_err,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW/8-1:0] d_sel,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            d_err,
   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW/8-1:0] m_sel,
   output logic [DW-1:0]   m_wdata,
   input  logic            m_gnt,
   input  logic            m_rvalid,
   input  logic [DW-1:0]   m_rdata,
   output logic            hold_flag_o
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

   arb_state_t            state, state_next;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  last_d, last_d_next;
   logic [1:0]            pick;
   owner_t                winner;

   arb_rr2 u_pick (
      .req    ({d_req, i_req}),
      .last_d (last_d),
      .gnt    (pick)
   );

   assign winner = pick[REQ_D] ? OWNER_D : OWNER_I;

   // Counter sits at zero in IDLE, so it reads 0 the cycle after a grant and counts from there
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB_IDLE;
         wait_cnt <= '0;
         last_d   <= 1'b1;
      end else begin
         state  <= state_next;
         last_d <= last_d_next;
         if (state == ARB_IDLE) wait_cnt <= '0;
         else                   wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Outputs are forced quiet while reset is asserted so a mid-access reset silences the bus at once
   always_comb begin
      state_next  = state;
      last_d_next = last_d;
      m_req       = 1'b0;
      m_we        = 1'b0;
      m_addr      = '0;
      m_sel       = '0;
      m_wdata     = '0;
      i_gnt       = 1'b0;
      i_rvalid    = 1'b0;
      i_rdata     = '0;
      i_err       = 1'b0;
      d_gnt       = 1'b0;
      d_rvalid    = 1'b0;
      d_rdata     = '0;
      d_err       = 1'b0;
      hold_flag_o = 1'b0;
      if (!rst) begin
         unique case (state)
            ARB_IDLE: begin
               if (pick[REQ_D]) begin
                  m_req   = 1'b1;
                  m_we    = d_we;
                  m_addr  = d_addr;
                  m_sel   = d_sel;
                  m_wdata = d_wdata;
                  d_gnt   = m_gnt;
               end else if (pick[REQ_I]) begin
                  m_req  = 1'b1;
                  m_addr = i_addr;
                  m_sel  = '1;
                  i_gnt  = m_gnt;
               end
               hold_flag_o = d_req && !d_gnt;
               if (m_req && m_gnt) begin
                  state_next  = (winner == OWNER_D) ? ARB_BUSY_D : ARB_BUSY_I;
                  last_d_next = (winner == OWNER_I);
               end
            end
            ARB_BUSY_I: begin
               if (m_rvalid) begin
                  i_rvalid   = 1'b1;
                  i_rdata    = m_rdata;
                  state_next = ARB_IDLE;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  i_rvalid   = 1'b1;
                  i_err      = 1'b1;
                  state_next = ARB_IDLE;
               end
            end
            ARB_BUSY_D: begin
               if (m_rvalid) begin
                  d_rvalid   = 1'b1;
                  d_rdata    = m_rdata;
                  state_next = ARB_IDLE;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  d_rvalid   = 1'b1;
                  d_err      = 1'b1;
                  state_next = ARB_IDLE;
               end
               hold_flag_o = !d_rvalid;
            end
            default: state_next = ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level reference model.
module tb_mem_bus_arbiter;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int SW       = DW / 8;
   localparam int MAX_WAIT = 15;
   localparam int CYCLES   = 3000;

   logic          clk;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt, i_rvalid, i_err;
   logic [DW-1:0] i_rdata;
   logic          d_req, d_we;
   logic [AW-1:0] d_addr;
   logic [SW-1:0] d_sel;
   logic [DW-1:0] d_wdata;
   logic          d_gnt, d_rvalid, d_err;
   logic [DW-1:0] d_rdata;
   logic          m_req, m_we;
   logic [AW-1:0] m_addr;
   logic [SW-1:0] m_sel;
   logic [DW-1:0] m_wdata;
   logic          m_gnt, m_rvalid;
   logic [DW-1:0] m_rdata;
   logic          hold_flag_o;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .hold_flag_o(hold_flag_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: who owns the bus (0 none, 1 I, 2 D), cycles since grant, who was served last
   int owner       = 0;
   int age         = 0;
   int last_served = 0;
   int mem_delay   = 0;
   int winner      = 0;

   bit            exp_m_req, exp_m_we, exp_i_gnt, exp_d_gnt;
   bit            exp_i_rvalid, exp_i_err, exp_d_rvalid, exp_d_err, exp_hold, exp_done;
   logic [AW-1:0] exp_m_addr;
   logic [SW-1:0] exp_m_sel;
   logic [DW-1:0] exp_m_wdata, exp_i_rdata, exp_d_rdata;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic computeExpected();
      bit resp_now, timed_out;
      exp_m_req = 0; exp_m_we = 0; exp_m_addr = '0; exp_m_sel = '0; exp_m_wdata = '0;
      exp_i_gnt = 0; exp_d_gnt = 0; exp_hold = 0; exp_done = 0;
      exp_i_rvalid = 0; exp_i_err = 0; exp_i_rdata = '0;
      exp_d_rvalid = 0; exp_d_err = 0; exp_d_rdata = '0;
      winner = 0;
      if (owner == 0) begin
         if (i_req && d_req) winner = (last_served == 2) ? 1 : 2;
         else if (d_req)     winner = 2;
         else if (i_req)     winner = 1;
         if (winner == 2) begin
            exp_m_req = 1; exp_m_we = d_we; exp_m_addr = d_addr;
            exp_m_sel = d_sel; exp_m_wdata = d_wdata; exp_d_gnt = m_gnt;
         end else if (winner == 1) begin
            exp_m_req = 1; exp_m_addr = i_addr; exp_m_sel = {SW{1'b1}}; exp_i_gnt = m_gnt;
         end
         exp_hold = d_req && !exp_d_gnt;
      end else begin
         resp_now  = m_rvalid;
         timed_out = (age == MAX_WAIT + 1);
         exp_done  = resp_now || timed_out;
         if (owner == 1) begin
            exp_i_rvalid = exp_done;
            exp_i_err    = !resp_now && timed_out;
            exp_i_rdata  = resp_now ? m_rdata : '0;
         end else begin
            exp_d_rvalid = exp_done;
            exp_d_err    = !resp_now && timed_out;
            exp_d_rdata  = resp_now ? m_rdata : '0;
            exp_hold     = !exp_done;
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("m_ctrl", 64'({m_req, m_we, m_sel}), 64'({exp_m_req, exp_m_we, exp_m_sel}));
      checkOutput("m_addr", 64'(m_addr), 64'(exp_m_addr));
      checkOutput("m_wdata", 64'(m_wdata), 64'(exp_m_wdata));
      checkOutput("gnt", 64'({i_gnt, d_gnt}), 64'({exp_i_gnt, exp_d_gnt}));
      checkOutput("i_resp", 64'({i_rvalid, i_err, i_rdata}), 64'({exp_i_rvalid, exp_i_err, exp_i_rdata}));
      checkOutput("d_resp", 64'({d_rvalid, d_err, d_rdata}), 64'({exp_d_rvalid, exp_d_err, exp_d_rdata}));
      checkOutput("hold", 64'(hold_flag_o), 64'(exp_hold));
   endtask

   task automatic applyStimulus(input bit force_tie);
      if (force_tie) begin
         i_req = 1; i_addr = 32'h100;
         d_req = 1; d_we = 1; d_addr = 32'h2004; d_sel = 4'b0011; d_wdata = 32'hBEEF;
         m_gnt = 1;
      end else begin
         if (!(i_req && !exp_i_gnt && $urandom_range(0, 9) != 0)) begin
            i_req  = ($urandom_range(0, 1) == 1);
            i_addr = $urandom;
         end
         if (!(d_req && !exp_d_gnt && $urandom_range(0, 9) != 0)) begin
            d_req   = ($urandom_range(0, 1) == 1);
            d_we    = ($urandom_range(0, 1) == 1);
            d_addr  = $urandom;
            d_sel   = SW'($urandom);
            d_wdata = $urandom;
         end
         m_gnt = ($urandom_range(0, 9) < 7);
      end
      m_rdata = $urandom;
      // Memory answers after its chosen delay, never (delay 0), or sends a stray pulse while idle
      if (owner != 0) m_rvalid = (mem_delay != 0) && (age == mem_delay);
      else            m_rvalid = ($urandom_range(0, 15) == 0);
   endtask

   task automatic updateModel();
      if (owner == 0) begin
         if (winner != 0 && m_gnt) begin
            owner       = winner;
            age         = 1;
            last_served = winner;
            mem_delay   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, MAX_WAIT));
         end
      end else if (exp_done) begin
         owner = 0; age = 0; mem_delay = 0;
      end else begin
         age++;
      end
   endtask

   task automatic checkResetQuiet(input string tag);
      checkOutput(tag, 64'({m_req, m_we, |m_addr, |m_sel, |m_wdata, i_gnt, d_gnt,
                            i_rvalid, i_err, |i_rdata, d_rvalid, d_err, |d_rdata, hold_flag_o}), 64'd0);
   endtask

   task automatic pulseReset();
      rst = 1;
      #1;
      checkResetQuiet("rst_mid");
      owner = 0; age = 0; last_served = 0; mem_delay = 0;
      exp_i_gnt = 0; exp_d_gnt = 0;
      rst = 0;
      #1;
   endtask

   initial begin
      rst = 1;
      i_req = 0; i_addr = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_sel = '0; d_wdata = '0;
      m_gnt = 0; m_rvalid = 0; m_rdata = '0;
      repeat (2) @(posedge clk);
      i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1;
      @(negedge clk);
      checkResetQuiet("rst_init");
      i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
      rst = 0;
      @(posedge clk);
      #1;
      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         if (cyc > 0 && $urandom_range(0, 149) == 0) pulseReset();
         applyStimulus(cyc == 0);
         @(negedge clk);
         computeExpected();
         compareAll();
         @(posedge clk);
         updateModel();
         #1;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
